muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencer for the shared multiply/divide resource in the EX stage of the 5-stage pipeline.
- Accepts one mult/multu/div/divu/mthi/mtlo per start pulse and times the multi-cycle busy window.
- Owns the architectural HI/LO registers and tells the hazard unit when an ID-stage md instruction must stall.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (legal 1..15)
- DIV_LAT, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  EX-stage md instruction valid this cycle
- op  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 = no-op
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  in  32  forwarded rt operand
- md_use_ID  in  1  ID-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  multi-cycle operation in flight
- hi  out  32  HI register
- lo  out  32  LO register
- stall_md  out  1  to hazard unit; combinational = md_use_ID & (busy | (start & op<=3))

Behaviour:
- Reset, sampled on a clk edge: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending results=0. Reset during BUSY aborts the operation; HI/LO are not updated.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, 4-bit down-counter cnt.
- IDLE with start and op in 0..3, at edge T:
  - Capture the full result into pend_hi/pend_lo, computed from that cycle's operands.
  - cnt := LAT-1 (MULT_LAT or DIV_LAT); go to BUSY.
  - busy is high for exactly LAT cycles after edge T.
- BUSY with cnt≠0: cnt decrements each edge.
- BUSY with cnt=0: at that edge hi:=pend_hi, lo:=pend_lo, state:=IDLE.
  - busy falls and the new hi/lo appear in the same cycle, at edge T+LAT.
- mthi/mtlo while IDLE: hi:=rs_val (op 4) or lo:=rs_val (op 5) at the same edge. busy stays 0. The other register is unchanged.
- start with op 6/7: no effect.
- start while BUSY, any op: ignored. The hazard unit guarantees this does not occur.
- The bench flags any start while BUSY as a protocol error.
- Arithmetic:
  - mult: signed 32x32 to 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64.
  - div/divu: lo=quotient, hi=remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divisor 0, both signed and unsigned: still busy for DIV_LAT cycles; hi/lo keep their pre-start values.
- stall_md covers three cases:
  - the cycle start is accepted;
  - every busy cycle;
  - mfhi/mflo in ID never reads a stale value. It deasserts in the cycle busy falls.
- hi/lo are read combinationally by mfhi/mflo in EX. There is no bypass of pend_* onto hi/lo.

Test Plan:
- Reset mid-op: reset while busy with cnt=3 → busy=0 next cycle, hi=lo=0, no later commit.
- Signed mult: rs=0xFFFFFFFE (-2), rt=3, start at edge T → busy=1 for 5 cycles; at T+5 busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Repeat with multu: hi=0x00000002, lo=0xFFFFFFFA.
- Signed div: rs=0xFFFFFFF9 (-7), rt=2, latency 10 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Overflow case 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo (busy stays 0, values visible the next cycle); divu by 0 → busy for 10 cycles, then hi=0x11, lo=0x22.
- Stall window: md_use_ID held 1 across a mult → stall_md=1 in the start cycle and all 5 busy cycles, 0 in the first idle cycle.
  - md_use_ID=0 throughout → stall_md=0 always.
- Ignored start: start with op=2 during BUSY → cnt, busy duration and result unaffected.
  - op=6 in IDLE → no state change.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the EX stage: times the busy window of each md
// operation, owns architectural HI/LO and raises the md stall request to the hazard unit.
module muldiv_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_use_ID,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall_md
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic [63:0] prod_s, prod_u;
   logic        div_signed, neg_a, neg_b, div_zero;
   logic [31:0] mag_a, mag_b, quo_u, rem_u, quo, rem;

   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   always_comb begin
      prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
      prod_u = {32'd0, rs_val} * {32'd0, rt_val};
   end

   // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
   always_comb begin
      div_signed = (op == OP_DIV);
      neg_a      = div_signed & rs_val[31];
      neg_b      = div_signed & rt_val[31];
      mag_a      = neg_a ? (32'd0 - rs_val) : rs_val;
      mag_b      = neg_b ? (32'd0 - rt_val) : rt_val;
      div_zero   = (rt_val == 32'd0);
      quo_u      = 32'd0;
      rem_u      = 32'd0;
      if (!div_zero) begin
         quo_u = mag_a / mag_b;
         rem_u = mag_a % mag_b;
      end
      quo = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
      rem = neg_a ? (32'd0 - rem_u) : rem_u;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = MULT_CNT;
                     state_d   = StBusy;
                  end
                  OP_MULTU: begin
                     pend_hi_d = prod_u[63:32];
                     pend_lo_d = prod_u[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = MULT_CNT;
                     state_d   = StBusy;
                  end
                  OP_DIV, OP_DIVU: begin
                     // A zero divisor still occupies the unit but leaves HI/LO untouched.
                     pend_hi_d = rem;
                     pend_lo_d = quo;
                     pend_wr_d = !div_zero;
                     cnt_d     = DIV_CNT;
                     state_d   = StBusy;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         StBusy: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               pend_wr_d = 1'b0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy     = (state_q == StBusy);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign stall_md = md_use_ID & (busy | (start & (op <= OP_DIVU)));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, HI/LO results, stall window, reset abort.
module tb_muldiv_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        md_use_ID;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_md;

   int checks;
   int errors;
   int proto_cnt;

   muldiv_ctrl #(
      .MULT_LAT(5),
      .DIV_LAT (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .md_use_ID(md_use_ID),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .stall_md (stall_md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Any start accepted while busy is a protocol violation; only one is injected on purpose.
   always @(posedge clk) begin
      if (!reset && start && busy) proto_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one md op, follow the busy window, then check the committed HI/LO.
   task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic use_id, input logic inject);
      int n;
      md_use_ID = use_id;
      start     = 1'b1;
      op        = o;
      rs_val    = a;
      rt_val    = b;
      #1;
      chk({tag, ".stall_start"}, 32'(stall_md), 32'(use_id));
      tick();
      start = 1'b0;
      n     = 0;
      while (busy && n < 40) begin
         n++;
         chk({tag, ".stall_busy"}, 32'(stall_md), 32'(use_id));
         if (inject && n == 3) begin
            start  = 1'b1;
            op     = 3'd2;
            rs_val = 32'd100;
            rt_val = 32'd7;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      chk({tag, ".latency"}, 32'(n), 32'(lat));
      chk({tag, ".busy_end"}, 32'(busy), 32'd0);
      chk({tag, ".stall_end"}, 32'(stall_md), 32'd0);
      chk({tag, ".hi"}, hi, ehi);
      chk({tag, ".lo"}, lo, elo);
      md_use_ID = 1'b0;
   endtask

   task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] ehi, input logic [31:0] elo);
      md_use_ID = 1'b1;
      start     = 1'b1;
      op        = o;
      rs_val    = a;
      #1;
      chk({tag, ".stall"}, 32'(stall_md), 32'd0);
      tick();
      start     = 1'b0;
      md_use_ID = 1'b0;
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".hi"}, hi, ehi);
      chk({tag, ".lo"}, lo, elo);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      proto_cnt = 0;
      reset     = 1'b1;
      start     = 1'b0;
      op        = 3'd0;
      rs_val    = 32'd0;
      rt_val    = 32'd0;
      md_use_ID = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.hi", hi, 32'd0);
      chk("reset.lo", lo, 32'd0);
      chk("reset.stall", 32'(stall_md), 32'd0);

      run_md("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0);
      run_md("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 1'b0);
      run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1,
             1'b1);
      run_md("div_negdiv", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD,
             1'b0, 1'b0);
      run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000,
             1'b0, 1'b0);

      move_to("mthi", 3'd4, 32'h0000_0011, 32'h0000_0011, 32'h8000_0000);
      move_to("mtlo", 3'd5, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);

      run_md("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 10, 32'h0000_0011, 32'h0000_0022,
             1'b1, 1'b0);
      run_md("div_zero", 3'd2, 32'hFFFF_FFF0, 32'd0, 10, 32'h0000_0011, 32'h0000_0022,
             1'b0, 1'b0);

      // op 6 is a no-op: nothing may change
      start  = 1'b1;
      op     = 3'd6;
      rs_val = 32'hDEAD_BEEF;
      rt_val = 32'd1;
      tick();
      start = 1'b0;
      chk("noop.busy", 32'(busy), 32'd0);
      chk("noop.hi", hi, 32'h0000_0011);
      chk("noop.lo", lo, 32'h0000_0022);

      run_md("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 1'b0);

      // Reset while cnt=3 aborts the mult; its result must never land.
      start  = 1'b1;
      op     = 3'd0;
      rs_val = 32'hFFFF_FFFE;
      rt_val = 32'd3;
      tick();
      start = 1'b0;
      tick();
      chk("rst_mid.busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid.busy", 32'(busy), 32'd0);
      chk("rst_mid.hi", hi, 32'd0);
      chk("rst_mid.lo", lo, 32'd0);
      repeat (8) tick();
      chk("rst_mid.busy_late", 32'(busy), 32'd0);
      chk("rst_mid.hi_late", hi, 32'd0);
      chk("rst_mid.lo_late", lo, 32'd0);

      chk("protocol.start_while_busy", 32'(proto_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
